// File: rtl/overcooked_pkg.sv
// ============================================================================
// Package     : overcooked_pkg
// Description : Shared game-state encoding, order-queue limits and score cap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package overcooked_pkg;

    typedef enum logic [2:0] {
        GS_WELCOME = 3'd0,
        GS_PLAY    = 3'd1,
        GS_END     = 3'd2
    } game_state_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } om_state_e;

    localparam int unsigned MAX_ORDERS = 4;
    localparam logic [9:0]  SCORE_CAP  = 10'd999;

    function automatic logic [9:0] sat_score(input logic [11:0] v);
        return (v > {2'b00, SCORE_CAP}) ? SCORE_CAP : v[9:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sec_tick.sv
// ============================================================================
// Module      : sec_tick
// Description : Divides the clock into one-cycle game-second pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_tick #(
    parameter int unsigned TICK_CYCLES = 65_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic sec_o
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign sec_o = enable_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/order_manager.sv
// ============================================================================
// Module      : order_manager
// Description : Round timer, score keeping and four-slot order queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_manager
    import overcooked_pkg::*;
#(
    parameter int unsigned TICK_CYCLES   = 65_000_000,
    parameter int unsigned GAME_SECONDS  = 180,
    parameter int unsigned ORDER_SECONDS = 30,
    parameter int unsigned SPAWN_SECONDS = 20,
    parameter int unsigned REWARD        = 20,
    parameter int unsigned PENALTY       = 10
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [2:0]      game_state_i,
    input  logic            deliver_i,
    output logic [7:0]      time_left_o,
    output logic [9:0]      point_total_o,
    output logic [3:0]      orders_o,
    output logic [3:0][4:0] order_times_o,
    output logic            deliver_ok_o,
    output logic            round_over_o
);

    localparam logic [7:0]  GAME_INIT  = 8'(GAME_SECONDS);
    localparam logic [4:0]  ORDER_INIT = 5'(ORDER_SECONDS);
    localparam logic [7:0]  SPAWN_LAST = 8'(SPAWN_SECONDS);
    localparam logic [11:0] REWARD_W   = 12'(REWARD);
    localparam logic [11:0] PENALTY_W  = 12'(PENALTY);

    om_state_e       state_q;
    logic [7:0]      time_q;
    logic [9:0]      points_q;
    logic [2:0]      count_q;
    logic [3:0][4:0] slots_q;
    logic [7:0]      spawn_q;
    logic            deliver_ok_q;
    logic            round_over_q;

    logic            playing;
    logic            run_en;
    logic            start;
    logic            sec;

    assign playing = (game_state_i == GS_PLAY);
    assign run_en  = (state_q == ST_RUN) && playing;
    assign start   = (state_q == ST_IDLE) && playing;

    sec_tick #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_sec_tick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (run_en),
        .clear_i  (start),
        .sec_o    (sec)
    );

    logic [3:0][4:0] exp_slots, del_slots, slots_d;
    logic [2:0]      exp_cnt, del_cnt, count_d;
    logic [2:0]      n_expired;
    logic [4:0]      dec;
    logic [11:0]     pen, pts_pen, pts_rew;
    logic [9:0]      points_d;
    logic [7:0]      time_d, spawn_d;
    logic            deliver_ok_d, round_over_d;

    // Order of a RUN step: age and compact, then deliver, then spawn.
    always_comb begin
        exp_slots = '0;
        exp_cnt   = '0;
        n_expired = '0;
        dec       = '0;
        if (sec) begin
            for (int i = 0; i < int'(MAX_ORDERS); i++) begin
                if (3'(i) < count_q) begin
                    dec = slots_q[i] - 5'd1;
                    if (dec == 5'd0) begin
                        n_expired = n_expired + 3'd1;
                    end else begin
                        exp_slots[exp_cnt[1:0]] = dec;
                        exp_cnt = exp_cnt + 3'd1;
                    end
                end
            end
        end else begin
            exp_slots = slots_q;
            exp_cnt   = count_q;
        end

        pen     = 12'(n_expired) * PENALTY_W;
        pts_pen = ({2'b00, points_q} > pen) ? ({2'b00, points_q} - pen) : 12'd0;

        deliver_ok_d = deliver_i && (exp_cnt != 3'd0);
        del_slots    = exp_slots;
        del_cnt      = exp_cnt;
        pts_rew      = pts_pen;
        if (deliver_ok_d) begin
            pts_rew   = pts_pen + REWARD_W + {7'd0, exp_slots[0]};
            del_slots = {5'd0, exp_slots[3:1]};
            del_cnt   = exp_cnt - 3'd1;
        end
        points_d = sat_score(pts_rew);

        slots_d = del_slots;
        count_d = del_cnt;
        spawn_d = spawn_q;
        if (sec) begin
            spawn_d = spawn_q + 8'd1;
            if (spawn_d == SPAWN_LAST) begin
                spawn_d = '0;
                if (del_cnt < 3'(MAX_ORDERS)) begin
                    slots_d[del_cnt[1:0]] = ORDER_INIT;
                    count_d = del_cnt + 3'd1;
                end
            end
        end

        time_d       = sec ? (time_q - 8'd1) : time_q;
        round_over_d = sec && (time_q == 8'd1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            time_q       <= '0;
            points_q     <= '0;
            count_q      <= '0;
            slots_q      <= '0;
            spawn_q      <= '0;
            deliver_ok_q <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            deliver_ok_q <= 1'b0;
            round_over_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (playing) begin
                        state_q  <= ST_RUN;
                        time_q   <= GAME_INIT;
                        points_q <= '0;
                        count_q  <= 3'd1;
                        slots_q  <= {15'd0, ORDER_INIT};
                        spawn_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (!playing) begin
                        state_q <= ST_IDLE;
                    end else begin
                        time_q       <= time_d;
                        points_q     <= points_d;
                        count_q      <= count_d;
                        slots_q      <= slots_d;
                        spawn_q      <= spawn_d;
                        deliver_ok_q <= deliver_ok_d;
                        if (round_over_d) begin
                            round_over_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!playing) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign time_left_o   = time_q;
    assign point_total_o = points_q;
    assign orders_o      = {1'b0, count_q};
    assign order_times_o = slots_q;
    assign deliver_ok_o  = deliver_ok_q;
    assign round_over_o  = round_over_q;

endmodule

`default_nettype wire

// File: tb/tb_order_manager.sv
// ============================================================================
// Module      : tb_order_manager
// Description : Scoreboard bench for two order_manager configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_order_manager;
    import overcooked_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [2:0] gs;
    logic       del;

    logic [7:0]      tl0, tl1;
    logic [9:0]      pts0, pts1;
    logic [3:0]      ord0, ord1;
    logic [3:0][4:0] ot0, ot1;
    logic            dok0, dok1, rov0, rov1;

    // Instance 0: short round; instance 1: long orders, spawn every second, big reward.
    int P_TICK  [2] = '{10, 3};
    int P_GAME  [2] = '{5, 40};
    int P_ORDER [2] = '{3, 31};
    int P_SPAWN [2] = '{2, 1};
    int P_REW   [2] = '{20, 200};
    int P_PEN   [2] = '{10, 10};

    order_manager #(
        .TICK_CYCLES(10), .GAME_SECONDS(5), .ORDER_SECONDS(3),
        .SPAWN_SECONDS(2), .REWARD(20), .PENALTY(10)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .game_state_i(gs), .deliver_i(del),
        .time_left_o(tl0), .point_total_o(pts0), .orders_o(ord0),
        .order_times_o(ot0), .deliver_ok_o(dok0), .round_over_o(rov0)
    );

    order_manager #(
        .TICK_CYCLES(3), .GAME_SECONDS(40), .ORDER_SECONDS(31),
        .SPAWN_SECONDS(1), .REWARD(200), .PENALTY(10)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .game_state_i(gs), .deliver_i(del),
        .time_left_o(tl1), .point_total_o(pts1), .orders_o(ord1),
        .order_times_o(ot1), .deliver_ok_o(dok1), .round_over_o(rov1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: 0 = waiting, 1 = round in progress, 2 = round finished.
    int m_mode [2];
    int m_tl   [2];
    int m_pts  [2];
    int m_tick [2];
    int m_spn  [2];
    int m_n    [2];
    int m_ord  [2][4];

    logic [43:0] exp_q0[$];
    logic [43:0] exp_q1[$];

    task automatic model_step(input int k, input bit rn, input logic [2:0] g,
                              input bit d, output logic [43:0] e);
        int q[$];
        int kept[$];
        int expired;
        bit sec, dok, rov;
        logic [19:0] t;
        dok = 1'b0;
        rov = 1'b0;
        sec = 1'b0;
        for (int i = 0; i < m_n[k]; i++) q.push_back(m_ord[k][i]);
        if (!rn) begin
            m_mode[k] = 0; m_tl[k] = 0; m_pts[k] = 0;
            m_tick[k] = 0; m_spn[k] = 0;
            q.delete();
        end else if (m_mode[k] == 0) begin
            if (g == GS_PLAY) begin
                m_mode[k] = 1; m_tl[k] = P_GAME[k]; m_pts[k] = 0;
                m_tick[k] = 0; m_spn[k] = 0;
                q.delete();
                q.push_back(P_ORDER[k]);
            end
        end else if (m_mode[k] == 1) begin
            if (g != GS_PLAY) begin
                m_mode[k] = 0;
            end else begin
                sec = (m_tick[k] == P_TICK[k] - 1);
                m_tick[k] = sec ? 0 : m_tick[k] + 1;
                if (sec) begin
                    m_tl[k] = m_tl[k] - 1;
                    expired = 0;
                    foreach (q[i]) begin
                        if (q[i] > 1) kept.push_back(q[i] - 1);
                        else expired++;
                    end
                    q = kept;
                    m_pts[k] = m_pts[k] - P_PEN[k] * expired;
                    if (m_pts[k] < 0) m_pts[k] = 0;
                    m_spn[k] = m_spn[k] + 1;
                end
                if (d && q.size() > 0) begin
                    m_pts[k] = m_pts[k] + P_REW[k] + q[0];
                    if (m_pts[k] > 999) m_pts[k] = 999;
                    void'(q.pop_front());
                    dok = 1'b1;
                end
                if (sec && m_spn[k] == P_SPAWN[k]) begin
                    m_spn[k] = 0;
                    if (q.size() < 4) q.push_back(P_ORDER[k]);
                end
                if (sec && m_tl[k] == 0) begin
                    rov = 1'b1;
                    m_mode[k] = 2;
                end
            end
        end else if (g != GS_PLAY) begin
            m_mode[k] = 0;
        end
        m_n[k] = q.size();
        t = '0;
        for (int i = 0; i < 4; i++) begin
            m_ord[k][i] = (i < q.size()) ? q[i] : 0;
            t[i*5 +: 5] = 5'(m_ord[k][i]);
        end
        e = {dok, rov, 8'(m_tl[k]), 10'(m_pts[k]), 4'(m_n[k]), t};
    endtask

    task automatic chk(input int k, input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL inst%0d %s @cycle %0d: got %0d, expected %0d", k, name, cycle, act, expv);
        end
    endtask

    task automatic compare_inst(input int k, input logic [43:0] a, input logic [43:0] e);
        chk(k, "deliver_ok",  int'(a[43]),    int'(e[43]));
        chk(k, "round_over",  int'(a[42]),    int'(e[42]));
        chk(k, "time_left",   int'(a[41:34]), int'(e[41:34]));
        chk(k, "point_total", int'(a[33:24]), int'(e[33:24]));
        chk(k, "orders",      int'(a[23:20]), int'(e[23:20]));
        for (int i = 0; i < 4; i++)
            chk(k, $sformatf("order_times[%0d]", i), int'(a[i*5 +: 5]), int'(e[i*5 +: 5]));
    endtask

    // Monitor: outputs are checked just after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) compare_inst(0, {dok0, rov0, tl0, pts0, ord0, ot0}, exp_q0.pop_front());
            if (exp_q1.size() > 0) compare_inst(1, {dok1, rov1, tl1, pts1, ord1, ot1}, exp_q1.pop_front());
        end
    end

    // One stimulus cycle: drive at the falling edge, predict the state after the next rising edge.
    task automatic cyc(input bit r, input logic [2:0] g, input bit d);
        logic [43:0] e;
        @(negedge clk);
        rst_n = r;
        gs    = g;
        del   = d;
        model_step(0, r, g, d, e);
        exp_q0.push_back(e);
        model_step(1, r, g, d, e);
        exp_q1.push_back(e);
    endtask

    initial begin
        logic [2:0] g;
        rst_n = 1'b0;
        gs    = GS_WELCOME;
        del   = 1'b0;

        repeat (3)  cyc(1'b0, GS_WELCOME, 1'b0);
        cyc(1'b1, GS_WELCOME, 1'b0);
        repeat (25) cyc(1'b1, GS_PLAY, 1'b0);
        repeat (60) cyc(1'b1, GS_PLAY, $urandom_range(0, 3) == 0);
        repeat (3)  cyc(1'b1, GS_END, 1'b1);
        repeat (2)  cyc(1'b1, GS_WELCOME, 1'b0);
        repeat (30) cyc(1'b1, GS_PLAY, $urandom_range(0, 2) == 0);
        repeat (5)  cyc(1'b1, GS_WELCOME, 1'b1);
        repeat (20) cyc(1'b1, GS_PLAY, $urandom_range(0, 2) == 0);
        repeat (2)  cyc(1'b0, GS_PLAY, 1'b1);
        repeat (40) cyc(1'b1, GS_PLAY, $urandom_range(0, 2) == 0);
        repeat (400) begin
            g = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : GS_PLAY;
            cyc(1'b1, g, $urandom_range(0, 2) == 0);
        end
        repeat (150) cyc(1'b1, GS_PLAY, $urandom_range(0, 1) == 0);

        @(posedge clk);
        #3;
        chk(0, "pending_expectations", exp_q0.size(), 0);
        chk(1, "pending_expectations", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
